display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexing controller for a NUM_DIGITS-digit common-anode seven-segment display. It drives the existing 4-bit display decoder one digit at a time over binary_code, and selects the matching digit enable. New display values are loaded through a valid/ready handshake. Values are committed only at frame boundaries, so a partial update is never visible.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 27000, clock cycles each digit stays lit (>=2)
DIGIT_W, 4, bits per digit nibble (fixed 4; matches the display decoder input)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan, 0 = all digits off
blank_lz  in  1  1 = suppress leading zeros
data_in  in  NUM_DIGITS*4  new value; nibble 0 = least-significant digit
data_valid  in  1  data_in valid
data_ready  out  1  controller can accept data_in
binary_code  out  4  nibble to the display decoder
digit_sel_n  out  NUM_DIGITS  active-low digit enables, one-hot-low
frame_done  out  1  one-cycle pulse after the last digit of a frame

Behaviour:
- Reset (async, rst_n=0):
  - state=BLANK; binary_code=0; digit_sel_n=all 1s; data_ready=1; frame_done=0.
  - active and shadow registers = 0; pending=0; prescaler=0; digit index idx=0.
- Prescaler: counts 0..REFRESH_DIV-1 in SCAN only. tick=1 when count==REFRESH_DIV-1, then count wraps to 0. Count is held at 0 in BLANK.
- Handshake:
  - data_ready = !pending.
  - Transfer occurs when data_valid && data_ready on a rising edge: shadow<=data_in, pending<=1.
  - data_valid while data_ready=0 is ignored. The source must hold the value.
- States:
  - BLANK: digit_sel_n all 1s. Moves to SCAN when enable=1, with idx=0.
    - If pending=1 on entry, shadow->active and pending clears on that same edge.
  - SCAN: on each tick, idx<=(idx+1) mod NUM_DIGITS.
    - The tick where idx==NUM_DIGITS-1 is the frame boundary. frame_done=1 for the following cycle.
    - If pending, active<=shadow and pending<=0 on that edge, so data_ready rises the next cycle.
  - SCAN -> BLANK: on the first edge with enable=0. idx<=0, prescaler<=0, outputs blanked on that edge. pending and shadow are retained.
- Outputs are registered and update on the same edge as idx:
  - binary_code = active nibble[idx].
  - digit_sel_n = ~(1<<idx).
  - After BLANK->SCAN, digit 0 is lit on the cycle after the transition edge.
- Leading-zero blanking: with blank_lz=1, digit i (i>0) is suppressed when nibbles i..NUM_DIGITS-1 of active are all 0.
  - Suppressed means digit_sel_n stays all 1s for that slot; the slot time still elapses.
  - Digit 0 is never suppressed.
- Simultaneous events:
  - Handshake accept on the same edge as frame commit: the commit uses the old shadow. The new value is captured because data_ready was 1 only if pending=0, so the two cannot collide.
  - enable falling on a frame-boundary tick: BLANK wins, no frame_done, and the pending commit waits until the next BLANK->SCAN.
- Reset mid-frame: returns immediately to reset values. A pending value is lost.
- Nibbles 0xA..0xF are passed through unchanged; decoding is the decoder's job.

Decomposition:
- Package display_pkg:
  - localparam DIGIT_W=4.
  - typedef enum logic {BLANK, SCAN} scan_state_t.
  - typedef logic [3:0] nibble_t.
- Sub-module refresh_tick_gen (parameter DIV; ports clk, rst_n, run, tick):
  - Holds the prescaler.
  - Clears its count when run=0.
- The display decoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 3 cycles with data_valid=1.
  - Required: digit_sel_n=4'b1111, binary_code=0, data_ready=1, and no capture while reset is held.
- Basic scan (REFRESH_DIV=4, load 16'h1234, enable=1):
  - Required: digit_sel_n walks 1110,1101,1011,0111, each for 4 cycles.
  - binary_code follows 4,3,2,1.
  - frame_done pulses once every 16 cycles.
- Tear-free update:
  - Stimulus: load 16'h5678 mid-frame.
  - Required: data_ready=0 until the boundary; the rest of the frame still shows 1234; the next frame shows 8,7,6,5; data_ready returns to 1 one cycle after the boundary.
- Backpressure:
  - Stimulus: second data_valid with 16'h9999 while pending.
  - Required: ignored; the display never shows 9999 unless it is re-presented after data_ready=1.
- Leading zeros:
  - Stimulus: load 16'h0070 with blank_lz=1.
  - Required: digits 0 and 1 lit (codes 0 and 7); slots 2 and 3 give digit_sel_n=1111.
  - With blank_lz=0, all four digits are lit.
- Enable / reset mid-operation:
  - Stimulus: drop enable at idx=2.
  - Required: next edge gives digit_sel_n=1111; on re-enable, the scan restarts at digit 0.
  - Asserting rst_n=0 mid-digit clears outputs asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types for the seven-segment display scan controller.
package display_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic {
    BLANK,
    SCAN
  } scan_state_t;

  typedef logic [DIGIT_W-1:0] nibble_t;

endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh prescaler: single-cycle tick every DIV cycles while run is high.
module refresh_tick_gen #(
  parameter int unsigned DIV = 27000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // tick is registered alongside the count so it is high exactly while count==LAST
  always_comb begin
    count_d = count_q;
    if (!run || (count_q == LAST)) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    tick_d = run && (count_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// New values are staged in a shadow register and committed only at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 27000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          blank_lz,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic [DIGIT_W-1:0]            binary_code,
  output logic [NUM_DIGITS-1:0]         digit_sel_n,
  output logic                          frame_done
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DATA_W = NUM_DIGITS * DIGIT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     active_q, active_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  data_ready_q, data_ready_d;
  logic                  frame_done_q, frame_done_d;
  nibble_t               binary_code_q, binary_code_d;
  logic [NUM_DIGITS-1:0] digit_sel_n_q, digit_sel_n_d;

  logic              tick;
  logic              run;
  logic              accept;
  logic              lit;
  logic              suppress;
  logic [DATA_W-1:0] upper;

  // Prescaler only runs while scanning; leaving SCAN clears it on the same edge.
  assign run = (state_q == SCAN) && enable;

  refresh_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    lit          = 1'b0;
    accept       = data_valid && data_ready_q;

    case (state_q)
      BLANK: begin
        if (enable) begin
          state_d = SCAN;
          idx_d   = '0;
          lit     = 1'b1;
          if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = BLANK;
          idx_d   = '0;
        end else begin
          lit = 1'b1;
          if (tick) begin
            if (idx_q == LAST_IDX) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      default: state_d = BLANK;
    endcase

    // Accept only happens with pending clear, so it never collides with a commit.
    if (accept) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
    data_ready_d = !pending_d;

    // Low nibble of upper is the selected digit; upper==0 means it and all above are zero.
    upper         = active_d >> (DIGIT_W * 32'(idx_d));
    suppress      = blank_lz && (idx_d != '0) && (upper == '0);
    binary_code_d = lit ? nibble_t'(upper) : '0;
    digit_sel_n_d = '1;
    if (lit && !suppress) begin
      digit_sel_n_d = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      data_ready_q  <= 1'b1;
      frame_done_q  <= 1'b0;
      binary_code_q <= '0;
      digit_sel_n_q <= '1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      data_ready_q  <= data_ready_d;
      frame_done_q  <= frame_done_d;
      binary_code_q <= binary_code_d;
      digit_sel_n_q <= digit_sel_n_d;
    end
  end

  assign data_ready  = data_ready_q;
  assign frame_done  = frame_done_q;
  assign binary_code = binary_code_q;
  assign digit_sel_n = digit_sel_n_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl against a time-based behavioural model.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        blank_lz;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  binary_code;
  logic [3:0]  digit_sel_n;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: scan position is derived from cycles elapsed since the scan started.
  bit          m_on;
  bit          m_pending;
  bit          m_fd;
  int          m_t;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic [9:0]  e_vec;

  display_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .blank_lz    (blank_lz),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .binary_code (binary_code),
    .digit_sel_n (digit_sel_n),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    bit          en, val, lz, rs, accept, commit, supp;
    logic [15:0] din;
    logic [3:0]  sel, code;
    int          idx;
    en = enable; val = data_valid; lz = blank_lz; rs = rst_n; din = data_in;
    @(posedge clk);
    if (!rs) begin
      m_on = 0; m_t = 0; m_active = '0; m_shadow = '0; m_pending = 0; m_fd = 0;
    end else begin
      accept = val && !m_pending;
      commit = 0;
      m_fd   = 0;
      if (m_on && !en) begin
        m_on = 0;
      end else if (m_on) begin
        m_t++;
        if (m_t % FRAME == 0) begin
          m_fd   = 1;
          commit = m_pending;
        end
      end else if (en) begin
        m_on   = 1;
        m_t    = 0;
        commit = m_pending;
      end
      if (commit) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      if (accept) begin
        m_shadow  = din;
        m_pending = 1;
      end
    end
    sel  = 4'hF;
    code = 4'h0;
    if (m_on) begin
      idx  = (m_t / DIV) % N;
      code = m_active[idx*4 +: 4];
      supp = lz && (idx > 0);
      for (int k = idx; k < N; k++) if (m_active[k*4 +: 4] != 4'h0) supp = 0;
      if (!supp) sel = ~(4'b0001 << idx);
    end
    e_vec = {sel, code, m_fd, !m_pending};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; blank_lz = 0; data_valid = 1; data_in = 16'($urandom);
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== 10'b1111_0000_0_1)
        $display("FAIL reset_hold cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, 10'b1111_0000_0_1);
      else n_pass++;
    end
    rst_n = 1; data_valid = 0;
    step();
    n_checks++;
    if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
      $display("FAIL reset_release: got %b want %b", {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
    else n_pass++;
  endtask

  task automatic test_basic_scan();
    int fd_cnt = 0;
    data_in = 16'h1234; data_valid = 1;
    step();
    n_checks++;
    if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
      $display("FAIL basic_load: got %b want %b", {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
    else n_pass++;
    data_valid = 0; enable = 1;
    for (int c = 0; c < 2 * FRAME + 1; c++) begin
      step();
      if (frame_done === 1'b1) fd_cnt++;
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL basic_scan cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    n_checks++;
    if (fd_cnt !== 2) $display("FAIL basic_frame_done_count: got %0d want 2", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_tear_free();
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL tear_pre cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    data_in = 16'h5678; data_valid = 1;
    step();
    data_valid = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL tear_scan cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
      if (m_t == 3 * FRAME) begin
        n_checks++;
        if ({binary_code, frame_done, data_ready} !== 6'b1000_1_1)
          $display("FAIL tear_boundary: got %b want %b", {binary_code, frame_done, data_ready}, 6'b1000_1_1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_pressure();
    int nines = 0;
    data_in = 16'h4321; data_valid = 1;
    step();
    data_in = 16'h9999;
    for (int c = 0; c < 40; c++) begin
      data_valid = !data_ready;
      step();
      if (binary_code === 4'h9) nines++;
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL bp_hold cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    n_checks++;
    if (nines !== 0) $display("FAIL bp_ignored: got %0d nine-cycles want 0", nines);
    else n_pass++;
    data_valid = 1;
    step();
    data_valid = 0;
    for (int c = 0; c < 36; c++) begin
      step();
      if (binary_code === 4'h9) nines++;
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL bp_represent cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    n_checks++;
    if ((nines > 0) !== 1'b1) $display("FAIL bp_accepted: got %0d nine-cycles want >0", nines);
    else n_pass++;
  endtask

  task automatic test_leading_zeros();
    int off_cnt = 0;
    for (int c = 0; c < 40 && data_ready !== 1'b1; c++) step();
    n_checks++;
    if (data_ready !== 1'b1) $display("FAIL lz_wait_ready: got %b want 1", data_ready);
    else n_pass++;
    blank_lz = 1; data_in = 16'h0070; data_valid = 1;
    step();
    data_valid = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      if (c >= FRAME && digit_sel_n === 4'hF) off_cnt++;
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL lz_on cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    n_checks++;
    if (off_cnt !== 2 * DIV) $display("FAIL lz_blank_slots: got %0d want %0d", off_cnt, 2 * DIV);
    else n_pass++;
    blank_lz = 0; off_cnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (digit_sel_n === 4'hF) off_cnt++;
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL lz_off cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    n_checks++;
    if (off_cnt !== 0) $display("FAIL lz_all_lit: got %0d blank cycles want 0", off_cnt);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    for (int c = 0; c < 24 && !(m_on && ((m_t / DIV) % N) == 2); c++) step();
    n_checks++;
    if (!(m_on && ((m_t / DIV) % N) == 2)) $display("FAIL en_reach_idx2: got t=%0d want digit 2", m_t);
    else n_pass++;
    enable = 0;
    step();
    n_checks++;
    if (digit_sel_n !== 4'hF) $display("FAIL en_drop_blank: got %b want 1111", digit_sel_n);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL en_blank cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    enable = 1;
    step();
    n_checks++;
    if (digit_sel_n !== 4'b1110) $display("FAIL en_restart_digit0: got %b want 1110", digit_sel_n);
    else n_pass++;
    for (int c = 0; c < FRAME; c++) begin
      step();
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL en_rescan cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    data_in = 16'hABCD; data_valid = 1;
    step();
    data_valid = 0;
    for (int c = 0; c < 5; c++) step();
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({digit_sel_n, binary_code, frame_done, data_ready} !== 10'b1111_0000_0_1)
      $display("FAIL async_reset: got %b want %b", {digit_sel_n, binary_code, frame_done, data_ready}, 10'b1111_0000_0_1);
    else n_pass++;
    step();
    rst_n = 1;
    for (int c = 0; c < FRAME + 2; c++) begin
      step();
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL post_reset cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int c = 0; c < 800; c++) begin
      rst_n  = ($urandom_range(0, 249) != 0);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      data_valid = ($urandom_range(0, 3) == 0);
      v = 16'($urandom);
      for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 0) v[k*4 +: 4] = 4'h0;
      data_in = v;
      step();
      n_checks++;
      if ({digit_sel_n, binary_code, frame_done, data_ready} !== e_vec)
        $display("FAIL random cyc %0d: got %b want %b", c, {digit_sel_n, binary_code, frame_done, data_ready}, e_vec);
      else n_pass++;
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_back_pressure();
    test_leading_zeros();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
